// File: rtl/qif_tdm_scheduler.sv
// rtl/qif_tdm_scheduler.sv - time-multiplexed QIF membrane update scheduler
// Define QIF_SAT_EN to saturate the membrane write-back; otherwise it wraps to 8 bits.
module qif_tdm_scheduler #(
    parameter int                N_NEURONS = 8,
    parameter int                ID_W      = 3,
    parameter logic signed [7:0] V_RESET   = -8'sd20,
    parameter logic signed [7:0] V_TH      = 8'sd50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_start,
    output logic                 step_busy,
    output logic                 step_done,
    output logic [ID_W-1:0]      syn_addr,
    input  logic signed [7:0]    syn_data,
    output logic                 spike_valid,
    output logic [ID_W-1:0]      spike_id,
    input  logic                 spike_ready,
    input  logic [ID_W-1:0]      probe_addr,
    output logic signed [7:0]    probe_v
);

`ifdef QIF_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, UPDATE, EMIT, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    idx;
    logic signed [7:0]  v_mem [N_NEURONS];

    logic signed [7:0]  v_cur;
    logic signed [7:0]  v_next;
    logic signed [10:0] v_ext;
    logic signed [10:0] syn_ext;
    logic signed [10:0] v_q;
    logic signed [10:0] syn_q;
    logic signed [10:0] v_sq;
    logic signed [10:0] v_sum;
    logic               at_last;

    assign v_cur   = v_mem[idx];
    assign probe_v = v_mem[probe_addr];
    assign at_last = (idx == LAST_IDX);

    always_comb begin
        v_ext   = {{3{v_cur[7]}}, v_cur};
        syn_ext = {{3{syn_data[7]}}, syn_data};
        // Bias negatives before the arithmetic shift so the quotient truncates toward zero.
        v_q     = (v_ext + (v_cur[7] ? 11'sd7 : 11'sd0)) >>> 3;
        syn_q   = (syn_ext + (syn_data[7] ? 11'sd3 : 11'sd0)) >>> 2;
        v_sq    = v_q * v_q;
        v_sum   = v_ext + v_sq + syn_q;
        v_next  = v_sum[7:0];
        if (SAT_EN) begin
            if (v_sum > 11'sd127) begin
                v_next = 8'sd127;
            end else if (v_sum < -11'sd128) begin
                v_next = -8'sd128;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            step_busy   <= 1'b0;
            step_done   <= 1'b0;
            syn_addr    <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_RESET;
            end
        end else begin
            step_done <= 1'b0;
            syn_addr  <= '0;
            case (state)
                IDLE: begin
                    if (step_start) begin
                        state     <= FETCH;
                        idx       <= '0;
                        step_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= UPDATE;
                end
                UPDATE: begin
                    // Spike decision uses the value stored before this step's update.
                    if (v_cur >= V_TH) begin
                        v_mem[idx]  <= V_RESET;
                        spike_valid <= 1'b1;
                        spike_id    <= idx;
                        state       <= EMIT;
                    end else begin
                        v_mem[idx] <= v_next;
                        if (at_last) begin
                            state     <= DONE;
                            step_done <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            idx      <= idx + 1'b1;
                            syn_addr <= idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        spike_id    <= '0;
                        if (at_last) begin
                            state     <= DONE;
                            step_done <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            idx      <= idx + 1'b1;
                            syn_addr <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    step_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/qif_tdm_scheduler.md
# qif_tdm_scheduler

Time-multiplexed scheduler that shares one 8-bit QIF membrane-update datapath among `N_NEURONS` virtual neurons. On each `step_start` it walks every neuron index in order: it fetches that neuron's synaptic current from an external current memory, applies the QIF update or threshold reset to the stored membrane value, and emits a spike event through a valid/ready handshake. It sits between the synaptic-current memory and the spike router, and replaces per-neuron instantiation of the update datapath.

## Interface
Parameters:
- `N_NEURONS`, default 8: number of virtual neurons; power of two, 2..64.
- `ID_W`, default 3: index width; equals log2(`N_NEURONS`).
- `V_RESET`, default -20: signed 8-bit reset potential.
- `V_TH`, default 50: signed 8-bit threshold potential.

Ports:
- `clk` in, 1 bit: sole clock; everything is updated on its rising edge.
- `rst_n` in, 1 bit: synchronous, active-high reset (high = reset, despite the name).
- `step_start` in, 1 bit: one-cycle request to run one timestep over all neurons.
- `step_busy` out, 1 bit: high whenever the FSM is not in IDLE.
- `step_done` out, 1 bit: one-cycle pulse when a timestep completes.
- `syn_addr` out, `ID_W` bits: neuron index whose current is being fetched.
- `syn_data` in, 8 bits signed: current for `syn_addr`; valid one cycle after `syn_addr` is presented.
- `spike_valid` out, 1 bit: spike event pending.
- `spike_id` out, `ID_W` bits: index of the spiking neuron.
- `spike_ready` in, 1 bit: consumer accepts the spike.
- `probe_addr` in, `ID_W` bits: debug read index.
- `probe_v` out, 8 bits signed: stored membrane value at `probe_addr`; combinational read.

## Operation
- State: membrane register file `v_mem[N_NEURONS]` (8-bit signed), index counter `idx`, FSM.
- FSM states and transitions:
  - IDLE: go to FETCH with `idx`=0 when `step_start` is high. `step_start` is ignored in every other state.
  - FETCH: drive `syn_addr`=`idx`, then go to UPDATE.
  - UPDATE: sample `syn_data`. Let `v`=`v_mem[idx]`.
    - If `v >= V_TH` (signed compare): write `V_RESET` and go to EMIT.
    - Otherwise write `v + (v/8)*(v/8) + syn_data/4` and go to FETCH with `idx`+1, or to DONE if `idx`=`N_NEURONS`-1.
  - EMIT: `spike_valid`=1, `spike_id`=`idx`. Hold until `spike_ready`=1 in the same cycle, then advance as UPDATE does on its non-spike path.
  - DONE: `step_done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - Division is signed and truncates toward zero (-20/8 = -2; -1/4 = 0).
  - Intermediates are at least 11 bits signed, so no intermediate overflow occurs.
  - The write-back value is narrowed to 8 bits per Configuration.
- The spike decision uses the stored value before the update. A neuron that crosses threshold during step k spikes during step k+1.
- Reset, including mid-step: every `v_mem` entry is set to `V_RESET` and the FSM returns to IDLE. Outputs after reset: `step_busy`=0, `step_done`=0, `spike_valid`=0, `spike_id`=0, `syn_addr`=0. Any pending spike is dropped.
- `spike_id` and `syn_addr` are 0 whenever their qualifying state is inactive.

## Timing
- Without spikes, `step_done` is high exactly 2·`N_NEURONS`+1 cycles after the cycle in which `step_start` is sampled.
- Each spike adds one EMIT cycle, plus one cycle per cycle of `spike_ready` low.
- `syn_data` latency is fixed at one cycle; the external memory must be synchronous-read.
- `probe_v` reflects a write on the cycle after the UPDATE that performs it.
- A `step_start` sampled in the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle.

## Configuration
- `QIF_SAT_EN` defined: the update result saturates to [-128, 127].
- `QIF_SAT_EN` undefined: the low 8 bits are kept (two's-complement wrap).
- With `V_TH`≤50 and 8-bit inputs the two modes are bit-identical. They differ only when `V_TH` is raised.

## Test plan
- Reset then probe every index -> `probe_v`=-20 for all neurons; all outputs 0.
- `syn_data`=0, one step -> every neuron goes -20→-16; `step_done` arrives 17 cycles after start (N=8); `spike_valid` never asserts.
- `syn_data`=127, `spike_ready`=1, repeated steps -> neuron 0 follows -20→15→47→103; the 4th step emits spikes for ids 0..7 in order and writes back -20.
- Spike stall: as above with `spike_ready` low for 5 cycles on id 3 -> `spike_valid`/`spike_id`=3 held stable; `idx` frozen; `step_done` delayed by 5 cycles.
- `V_TH`=127, `syn_data`=127, 4 steps -> step 4 gives 127 with `QIF_SAT_EN` defined, 22 without it; step 5 spikes only in the saturated build.
- `rst_n` pulsed during EMIT -> `spike_valid` drops the next cycle; FSM returns to IDLE; all `probe_v`=-20; the next `step_start` runs normally.
